// File: rtl/dec_seq_ctrl.sv
// rtl/dec_seq_ctrl.sv - decoder sequencing FSM: request accept, datapath launch/wait with timeout, held response.
// Optional statistics counters are enabled by defining DEC_SEQ_STATS_EN.
module dec_seq_ctrl #(
  parameter int TIMEOUT = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_codeword,
  output logic [31:0] dp_codeword,
  output logic        dp_start,
  input  logic        dp_done,
  input  logic        dp_are_errors,
  input  logic        dp_one_error,
  input  logic [4:0]  dp_err_col,
  input  logic [31:0] dp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_num_errors,
  output logic [4:0]  rsp_err_col,
  output logic        timeout_err,
  input  logic        clr_stats,
  output logic [15:0] cnt_total,
  output logic [15:0] cnt_corr,
  output logic [15:0] cnt_uncorr
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

  state_t      state, state_nx;
  logic [3:0]  timer;
  logic        done_hit, timeout_hit;
  logic [1:0]  num_nx;
  logic [4:0]  col_nx;

  assign req_ready   = (state == IDLE);
  assign dp_start    = (state == LAUNCH);
  // dp_done on the last allowed WAIT cycle beats the timeout.
  assign done_hit    = (state == WAIT) && dp_done;
  assign timeout_hit = (state == WAIT) && !dp_done && (timer == TIMER_LAST);

  always_comb begin
    num_nx = 2'b00;
    col_nx = 5'd0;
    if (dp_are_errors && dp_one_error) begin
      num_nx = 2'b01;
      col_nx = dp_err_col;
    end else if (dp_are_errors) begin
      num_nx = 2'b10;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (done_hit || timeout_hit) state_nx = HOLD;
      HOLD:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      timer          <= 4'd0;
      dp_codeword    <= 32'd0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 32'd0;
      rsp_num_errors <= 2'b00;
      rsp_err_col    <= 5'd0;
      timeout_err    <= 1'b0;
    end else begin
      state       <= state_nx;
      timeout_err <= timeout_hit;
      if (req_valid && req_ready) dp_codeword <= req_codeword;
      if (state == LAUNCH) timer <= 4'd0;
      else if (state == WAIT) timer <= timer + 4'd1;
      if (done_hit) begin
        rsp_valid      <= 1'b1;
        rsp_data       <= dp_data;
        rsp_num_errors <= num_nx;
        rsp_err_col    <= col_nx;
      end else if (timeout_hit) begin
        rsp_valid      <= 1'b1;
        rsp_data       <= 32'd0;
        rsp_num_errors <= 2'b11;
        rsp_err_col    <= 5'd0;
      end else if (state == HOLD && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef DEC_SEQ_STATS_EN
  logic [15:0] total_q, corr_q, uncorr_q;

  // Clear takes priority over a same-cycle completion.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      total_q  <= 16'd0;
      corr_q   <= 16'd0;
      uncorr_q <= 16'd0;
    end else if (done_hit || timeout_hit) begin
      if (total_q != 16'hFFFF) total_q <= total_q + 16'd1;
      if (done_hit && num_nx == 2'b01 && corr_q != 16'hFFFF) corr_q <= corr_q + 16'd1;
      if ((timeout_hit || num_nx == 2'b10) && uncorr_q != 16'hFFFF) uncorr_q <= uncorr_q + 16'd1;
    end
  end

  assign cnt_total  = total_q;
  assign cnt_corr   = corr_q;
  assign cnt_uncorr = uncorr_q;
`else
  logic unused_clr_stats;
  assign unused_clr_stats = clr_stats;
  assign cnt_total  = 16'd0;
  assign cnt_corr   = 16'd0;
  assign cnt_uncorr = 16'd0;
`endif

endmodule

// File: tb/tb_dec_seq_ctrl.sv
// tb/tb_dec_seq_ctrl.sv - scoreboard bench for dec_seq_ctrl (directed vectors; honours DEC_SEQ_STATS_EN).
module tb_dec_seq_ctrl;
  localparam int TO = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_codeword = 32'd0, dp_codeword;
  logic        dp_start;
  logic        dp_done = 1'b0, dp_are_errors = 1'b0, dp_one_error = 1'b0;
  logic [4:0]  dp_err_col = 5'd0;
  logic [31:0] dp_data = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_num_errors;
  logic [4:0]  rsp_err_col;
  logic        timeout_err;
  logic        clr_stats = 1'b0;
  logic [15:0] cnt_total, cnt_corr, cnt_uncorr;

  dec_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_codeword(req_codeword), .dp_codeword(dp_codeword), .dp_start(dp_start),
    .dp_done(dp_done), .dp_are_errors(dp_are_errors), .dp_one_error(dp_one_error),
    .dp_err_col(dp_err_col), .dp_data(dp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_num_errors(rsp_num_errors), .rsp_err_col(rsp_err_col),
    .timeout_err(timeout_err), .clr_stats(clr_stats), .cnt_total(cnt_total),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  num;
    logic [4:0]  col;
    logic        to;
  } rsp_t;

  rsp_t sb[$];
  rsp_t cur;
  int   checks = 0, failures = 0;
  int   n_start = 0, exp_start = 0;
  logic prev_valid = 1'b0;
  logic [15:0] e_total = 0, e_corr = 0, e_uncorr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Monitor: pop on every rising rsp_valid, then require stability while held.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (dp_start) n_start++;
      if (rsp_valid && !prev_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("rsp_data", rsp_data, cur.data);
          chk("rsp_num_errors", 32'(rsp_num_errors), 32'(cur.num));
          chk("rsp_err_col", 32'(rsp_err_col), 32'(cur.col));
          chk("timeout_err", 32'(timeout_err), 32'(cur.to));
        end
      end else if (rsp_valid) begin
        chk("hold_data", rsp_data, cur.data);
        chk("hold_num", 32'(rsp_num_errors), 32'(cur.num));
        chk("hold_col", 32'(rsp_err_col), 32'(cur.col));
        chk("timeout_pulse", 32'(timeout_err), 32'd0);
      end
      prev_valid = rsp_valid;
    end
  end

  task automatic upd_stats(input logic [1:0] num, input logic clr);
`ifdef DEC_SEQ_STATS_EN
    if (clr) begin
      e_total = 0; e_corr = 0; e_uncorr = 0;
    end else begin
      if (e_total != 16'hFFFF) e_total++;
      if (num == 2'b01 && e_corr != 16'hFFFF) e_corr++;
      if (num[1] && e_uncorr != 16'hFFFF) e_uncorr++;
    end
`endif
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_cnt_total"}, 32'(cnt_total), 32'(e_total));
    chk({tag, "_cnt_corr"}, 32'(cnt_corr), 32'(e_corr));
    chk({tag, "_cnt_uncorr"}, 32'(cnt_uncorr), 32'(e_uncorr));
  endtask

  // Runs one request; called at a negedge. done_at<0 means dp_done never comes.
  task automatic do_req(input logic [31:0] cw, input int done_at, input logic are, input logic one,
                        input logic [4:0] col, input logic [31:0] data, input int hold,
                        input logic clr, input logic keep_valid);
    rsp_t e;
    int   n, k, exp_k;
    logic timed_out;
    timed_out = (done_at < 0) || (done_at >= TO);
    if (timed_out) begin
      e.data = 32'd0; e.num = 2'b11; e.col = 5'd0; e.to = 1'b1;
      exp_k = TO;
    end else begin
      e.data = data; e.to = 1'b0;
      e.num  = !are ? 2'b00 : (one ? 2'b01 : 2'b10);
      e.col  = (are && one) ? col : 5'd0;
      exp_k  = done_at + 1;
    end
    sb.push_back(e);
    req_valid = 1'b1; req_codeword = cw;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < 50), 32'd1);
    exp_start++;
    @(negedge clk);
    if (!keep_valid) req_valid = 1'b0;
    chk("dp_start_launch", 32'(dp_start), 32'd1);
    chk("dp_codeword", dp_codeword, cw);
    @(negedge clk);
    k = 0;
    while (!rsp_valid && k < 40) begin
      dp_done = (k == done_at); dp_are_errors = are; dp_one_error = one;
      dp_err_col = col; dp_data = data;
      clr_stats = clr && (k == done_at);
      @(negedge clk);
      k++;
    end
    dp_done = 1'b0; clr_stats = 1'b0;
    chk("wait_cycles", 32'(k), 32'(exp_k));
    if (done_at == 0) chk("latency_from_accept", 32'(k + 2), 32'd3);
    upd_stats(e.num, clr);
    chk_stats("post_rsp");
    // Hold with stray dp_done activity that must be ignored.
    for (int i = 0; i < hold; i++) begin
      dp_done = 1'b1; dp_data = ~data; dp_are_errors = ~are;
      @(negedge clk);
    end
    dp_done = 1'b0;
    chk("dp_codeword_hold", dp_codeword, cw);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", 32'(rsp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_dp_start", 32'(dp_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_dp_codeword", dp_codeword, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_num", 32'(rsp_num_errors), 32'd0);
    chk("rst_col", 32'(rsp_err_col), 32'd0);
    chk_stats("rst");
    rst = 1'b0;
    // Stray dp_done in IDLE must not produce anything.
    dp_done = 1'b1; @(negedge clk); dp_done = 1'b0;
    @(negedge clk);
    chk("idle_done_ignored", 32'(rsp_valid), 32'd0);

    do_req(32'h0000008A, 0, 1'b0, 1'b0, 5'd0, 32'h0000008A, 0, 1'b0, 1'b0);
    do_req(32'h00001234, 0, 1'b1, 1'b1, 5'd5, 32'h00001230, 4, 1'b0, 1'b0);
    do_req(32'hAAAAAAAA, 2, 1'b1, 1'b0, 5'd7, 32'h55555555, 1, 1'b0, 1'b0);
    do_req(32'hDEADBEEF, -1, 1'b0, 1'b0, 5'd0, 32'h11111111, 2, 1'b0, 1'b0);
    do_req(32'hCAFEF00D, TO - 1, 1'b1, 1'b1, 5'd31, 32'hCAFEF00C, 1, 1'b0, 1'b0);

    // Reset while in WAIT aborts silently.
    req_valid = 1'b1; req_codeword = 32'h0BADF00D;
    @(negedge clk);
    req_valid = 1'b0; exp_start++;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    e_total = 0; e_corr = 0; e_uncorr = 0;
    chk("rstwait_req_ready", 32'(req_ready), 32'd1);
    chk("rstwait_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstwait_dp_codeword", dp_codeword, 32'd0);
    chk_stats("rstwait");
    repeat (TO + 2) @(negedge clk);
    chk("rstwait_no_rsp", 32'(rsp_valid), 32'd0);

    // Back-to-back with req_valid held high throughout.
    do_req(32'h00000001, 0, 1'b0, 1'b0, 5'd0, 32'h00000001, 0, 1'b0, 1'b1);
    do_req(32'h00000002, 1, 1'b1, 1'b1, 5'd2, 32'h00000003, 0, 1'b0, 1'b1);
    do_req(32'h00000004, 0, 1'b1, 1'b0, 5'd0, 32'h00000004, 0, 1'b0, 1'b0);

`ifdef DEC_SEQ_STATS_EN
    force dut.total_q = 16'hFFFE;
    force dut.corr_q  = 16'hFFFF;
    #1;
    release dut.total_q;
    release dut.corr_q;
    e_total = 16'hFFFE; e_corr = 16'hFFFF;
`endif
    do_req(32'h10000000, 0, 1'b1, 1'b1, 5'd1, 32'h10000001, 0, 1'b0, 1'b0);
    do_req(32'h20000000, 0, 1'b1, 1'b1, 5'd3, 32'h20000008, 0, 1'b0, 1'b0);
    do_req(32'h30000000, 0, 1'b1, 1'b0, 5'd0, 32'h30000000, 0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    chk("dp_start_count", 32'(n_start), 32'(exp_start));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
